// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction fetch with a one-entry park buffer and the IF/ID
//               pipeline register. Define DELAY_SLOT_EN to deliver the word
//               after a taken branch; otherwise that word is squashed.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [15:0] branch_addr_i,
    output logic        mem_req_o,
    output logic [15:0] mem_addr_o,
    input  logic [15:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic [15:0] pc_o,
    output logic [15:0] inst_o,
    output logic        inst_valid_o
);

    localparam logic [0:0] c_st_fetch = 1'b0;
    localparam logic [0:0] c_st_hold  = 1'b1;

    logic [0:0]  r_state;
    logic [15:0] r_fetch_pc;
    logic        r_req;
    logic        r_redirect_pending;
    logic [15:0] r_redirect_addr;
    logic [15:0] r_buf_inst;
    logic [15:0] r_inst;
    logic [15:0] r_pc;
    logic        r_valid;

    logic [0:0]  w_state_next;
    logic        w_ack;
    logic        w_branch;
    logic        w_redirect;
    logic        w_release;
    logic        w_park;
    logic        w_squash;
    logic [15:0] w_target;
    logic [15:0] w_pc_inc;
    logic [15:0] w_next_pc;
    logic [15:0] w_word;

    // r_req stays low for one cycle after reset, so a late ack from a
    // request dropped by reset is never taken.
    assign w_ack      = r_req & (r_state == c_st_fetch) & mem_ack_i;
    assign w_branch   = branch_flag_i & r_valid & ~stall_i;
    assign w_redirect = w_branch | r_redirect_pending;
    assign w_target   = w_branch ? branch_addr_i : r_redirect_addr;
    assign w_pc_inc   = r_fetch_pc + 16'd1;
    assign w_next_pc  = w_redirect ? w_target : w_pc_inc;
    assign w_park     = (r_state == c_st_fetch) & w_ack & stall_i;
    assign w_release  = ~stall_i & (((r_state == c_st_fetch) & w_ack) |
                                    (r_state == c_st_hold));
    assign w_word     = (r_state == c_st_hold) ? r_buf_inst : mem_rdata_i;

`ifdef DELAY_SLOT_EN
    assign w_squash = 1'b0;
`else
    assign w_squash = w_redirect;
`endif

    always_comb begin
        w_state_next = r_state;
        if (r_state == c_st_fetch) begin
            if (w_park) begin
                w_state_next = c_st_hold;
            end
        end else if (!stall_i) begin
            w_state_next = c_st_fetch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state            <= c_st_fetch;
            r_fetch_pc         <= RESET_PC;
            r_req              <= 1'b0;
            r_redirect_pending <= 1'b0;
            r_redirect_addr    <= 16'h0000;
            r_buf_inst         <= NOP_INST;
            r_inst             <= NOP_INST;
            r_pc               <= 16'h0000;
            r_valid            <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_req   <= (w_state_next == c_st_fetch);
            if (w_release) begin
                // Word completes into decode: this is the only fetch_pc update.
                r_fetch_pc <= w_next_pc;
                if (w_redirect) begin
                    r_redirect_pending <= 1'b0;
                end
                if (w_squash) begin
                    r_inst  <= NOP_INST;
                    r_pc    <= 16'h0000;
                    r_valid <= 1'b0;
                end else begin
                    r_inst  <= w_word;
                    r_pc    <= w_pc_inc;
                    r_valid <= 1'b1;
                end
            end else begin
                if (w_park) begin
                    r_buf_inst <= mem_rdata_i;
                end else if (!stall_i) begin
                    r_inst  <= NOP_INST;
                    r_pc    <= 16'h0000;
                    r_valid <= 1'b0;
                end
                if (w_branch) begin
                    r_redirect_pending <= 1'b1;
                    r_redirect_addr    <= branch_addr_i;
                end
            end
        end
    end

    assign mem_req_o    = r_req;
    assign mem_addr_o   = r_fetch_pc;
    assign pc_o         = r_pc;
    assign inst_o       = r_inst;
    assign inst_valid_o = r_valid;

endmodule
`default_nettype wire
